// File: rtl/instruction_sequencer_if.sv
// Byte-wide memory port shared by instruction fetch and data access.
// The sequencer is the master; the memory (or arbiter) is the slave.
interface instruction_sequencer_if;
    logic [7:0] mem_addr;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit core.
// Owns the zero flag and is the only source of program-counter advance.
module instruction_sequencer (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [7:0]                      pc_address,
    output logic                            pc_enable,
    output logic                            pc_jump,
    output logic                            pc_jz,
    output logic [7:0]                      pc_target,
    output logic                            zero_flag,
    instruction_sequencer_if.master         bus,
    output logic [3:0]                      rf_rd_addr,
    output logic [3:0]                      rf_rs_addr,
    input  logic [7:0]                      rf_rd_data,
    output logic                            rf_we,
    output logic [7:0]                      rf_wdata,
    output logic [1:0]                      alu_op,
    input  logic [7:0]                      alu_result,
    input  logic                            alu_zero,
    output logic                            halted,
    output logic                            illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_HI, S_FETCH_LO, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t      state, state_n;
    logic [15:0] ir;
    logic        ir_hi_ld, ir_lo_ld, zf_ld, ill_set;
    logic [3:0]  opcode;
    logic        is_alu;

    assign opcode     = ir[15:12];
    assign is_alu     = (opcode[3:2] == 2'b01);
    assign pc_target  = ir[7:0];
    assign rf_rd_addr = ir[11:8];
    assign rf_rs_addr = ir[3:0];
    assign halted     = (state == S_HALT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ir        <= 16'h0000;
            zero_flag <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state <= state_n;
            if (ir_hi_ld) ir[15:8] <= bus.mem_rdata;
            if (ir_lo_ld) ir[7:0]  <= bus.mem_rdata;
            if (zf_ld)    zero_flag <= alu_zero;
            if (ill_set)  illegal   <= 1'b1;
        end
    end

    // All strobes are decoded from the registered state, so an async reset
    // drops them in the same instant it forces IDLE.
    always_comb begin
        state_n       = state;
        ir_hi_ld      = 1'b0;
        ir_lo_ld      = 1'b0;
        zf_ld         = 1'b0;
        ill_set       = 1'b0;
        pc_enable     = 1'b0;
        pc_jump       = 1'b0;
        pc_jz         = 1'b0;
        bus.mem_addr  = 8'h00;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wdata = 8'h00;
        rf_we         = 1'b0;
        rf_wdata      = 8'h00;
        alu_op        = 2'b00;
        case (state)
            S_IDLE: if (start) state_n = S_FETCH_HI;
            S_FETCH_HI: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = pc_address;
                if (bus.mem_ready) begin
                    ir_hi_ld = 1'b1;
                    state_n  = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = pc_address + 8'd1;
                if (bus.mem_ready) begin
                    ir_lo_ld = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                if (is_alu) begin
                    alu_op    = opcode[1:0];
                    rf_we     = 1'b1;
                    rf_wdata  = alu_result;
                    zf_ld     = 1'b1;
                    pc_enable = 1'b1;
                    state_n   = S_FETCH_HI;
                end else begin
                    case (opcode)
                        OP_NOP: begin
                            pc_enable = 1'b1;
                            state_n   = S_FETCH_HI;
                        end
                        OP_LDI: begin
                            rf_we     = 1'b1;
                            rf_wdata  = ir[7:0];
                            pc_enable = 1'b1;
                            state_n   = S_FETCH_HI;
                        end
                        OP_LOAD, OP_STORE: state_n = S_MEM;
                        OP_JMP: begin
                            pc_enable = 1'b1;
                            pc_jump   = 1'b1;
                            state_n   = S_FETCH_HI;
                        end
                        OP_JZ: begin
                            pc_enable = 1'b1;
                            pc_jz     = 1'b1;
                            state_n   = S_FETCH_HI;
                        end
                        OP_HALT: state_n = S_HALT;
                        default: begin
                            ill_set = 1'b1;
                            state_n = S_HALT;
                        end
                    endcase
                end
            end
            S_MEM: begin
                bus.mem_addr = ir[7:0];
                if (opcode == OP_LOAD) begin
                    bus.mem_read = 1'b1;
                end else begin
                    bus.mem_write = 1'b1;
                    bus.mem_wdata = rf_rd_data;
                end
                if (bus.mem_ready) begin
                    pc_enable = 1'b1;
                    if (opcode == OP_LOAD) begin
                        rf_we    = 1'b1;
                        rf_wdata = bus.mem_rdata;
                    end
                    state_n = S_FETCH_HI;
                end
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle control FSM for the 8-bit CPU core. Fetches 16-bit instructions as two bytes from the shared byte-wide memory port, decodes them, and drives the register file, ALU, memory and the program counter's `enable`/`jump`/`jz`/`zero_flag` inputs. It is the only block that advances the program counter and the only owner of the architectural zero flag.

## Interface

Parameters:
- none. Widths are fixed: 8-bit data and address, 16-bit instructions, 16 registers.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: leave IDLE and begin fetching. Sampled only in IDLE.
- `pc_address` in 8: current program-counter value.
- `pc_enable` out 1: one-cycle strobe; the program counter updates on this edge.
- `pc_jump` out 1: unconditional jump qualifier; valid only with `pc_enable`.
- `pc_jz` out 1: jump-if-zero qualifier; valid only with `pc_enable`.
- `pc_target` out 8: jump address, equal to instruction bits [7:0].
- `zero_flag` out 1: registered architectural zero flag.
- `mem_addr` out 8: memory byte address.
- `mem_read` / `mem_write` out 1: request strobes, held until `mem_ready`.
- `mem_wdata` out 8: store data.
- `mem_rdata` in 8: read data, valid in the `mem_ready` cycle.
- `mem_ready` in 1: transaction completes in this cycle.
- `rf_rd_addr` out 4: instruction bits [11:8].
- `rf_rs_addr` out 4: instruction bits [3:0].
- `rf_rd_data` in 8: combinational read of `rf_rd_addr`.
- `rf_we` out 1: register write strobe.
- `rf_wdata` out 8: register write data.
- `alu_op` out 2: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `alu_result` in 8: combinational ALU output.
- `alu_zero` in 1: ALU result is zero.
- `halted` out 1: HALT executed or illegal opcode decoded. Sticky until `reset`.
- `illegal` out 1: illegal opcode decoded. Sticky until `reset`.

## Operation

- Instruction word, big-endian: high byte at `pc_address`, low byte at `pc_address+1` (8-bit wrap, so 0xFF+1 = 0x00).
- Fields: [15:12] opcode, [11:8] rd, [7:0] imm/address, [3:0] rs.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd ← imm.
  - 2 LOAD: rd ← mem[imm].
  - 3 STORE: mem[imm] ← rd.
  - 4–7 ALU: `alu_op` = opcode[1:0]; rd ← rd op rs; `zero_flag` ← `alu_zero`.
  - 8 JMP.
  - 9 JZ.
  - F HALT.
  - A–E illegal.
- States:
  - IDLE → FETCH_HI when `start`=1.
  - FETCH_HI: `mem_read`=1, `mem_addr`=pc. On `mem_ready`, latch IR[15:8] → FETCH_LO.
  - FETCH_LO: `mem_read`=1, `mem_addr`=pc+1. On `mem_ready`, latch IR[7:0] → DECODE.
  - DECODE: one cycle → EXEC for all opcodes.
  - EXEC, by opcode:
    - NOP / LDI / ALU: `rf_we` for LDI and ALU; `pc_enable`=1 → FETCH_HI.
    - JMP: `pc_enable`=1, `pc_jump`=1 → FETCH_HI.
    - JZ: `pc_enable`=1, `pc_jz`=1 → FETCH_HI. The program counter selects the target or the fall-through using `zero_flag`.
    - LOAD / STORE: → MEM.
    - HALT: → HALT.
    - Illegal: set `illegal` → HALT.
  - MEM: `mem_addr`=imm, `mem_read` (LOAD) or `mem_write` (STORE) held. On `mem_ready`: LOAD asserts `rf_we` with `rf_wdata`=`mem_rdata`; both assert `pc_enable` → FETCH_HI.
  - HALT: `halted`=1, no strobes, terminal until `reset`.
- `zero_flag` changes only on ALU EXEC cycles. LDI, LOAD and JZ leave it unchanged.
- A JZ sees the flag from the most recent completed ALU instruction.
- `mem_read` and `mem_write` are never asserted together.
- At most one of `pc_jump` / `pc_jz` is set, and only while `pc_enable`=1.

## Timing

- Reset (asynchronous): state IDLE; IR = 0x0000. All outputs 0: `pc_*`, `zero_flag`, `mem_*` strobes and address, `rf_we`, `alu_op`, `halted`, `illegal`.
- Reset mid-transaction abandons it. Strobes drop asynchronously.
- With zero-wait memory (`mem_ready` tied to 1):
  - NOP / LDI / ALU / JMP / JZ take 4 cycles: FETCH_HI, FETCH_LO, DECODE, EXEC.
  - LOAD / STORE take 5 cycles.
- Each memory wait cycle adds 1 cycle and holds address, strobes and write data stable.
- `pc_enable` is high for exactly one cycle per retired instruction. `pc_address` is stable from FETCH_HI through that cycle.
- `rf_we` and `pc_enable` for an instruction occur in the same cycle.
- `start` asserted outside IDLE is ignored.

## Test plan

- Zero-wait memory. Program: LDI r1,0x05; LDI r2,0x05; SUB r1,r2; JZ 0x20. Expect `zero_flag`=1 after SUB, a `pc_enable`+`pc_jz` pulse, and `rf_we` with `rf_wdata`=0x00 on r1.
- `mem_ready` held low 3 cycles on each fetch byte of NOP. Expect the instruction to take 10 cycles, with `mem_addr` stable at pc then pc+1.
- STORE r3,0x40 with r3=0xA5 and 2 wait states. Expect `mem_write`=1, `mem_addr`=0x40, `mem_wdata`=0xA5 for 3 cycles, then one `pc_enable` and no `rf_we`.
- Fetch at pc=0xFF. Expect the second fetch byte at `mem_addr`=0x00.
- Opcode 0xB. Expect `illegal`=1 and `halted`=1 after EXEC, no further `pc_enable` or memory strobes, and no change on a later `start`.
- Assert `reset` during MEM of a LOAD. Expect all strobes low immediately, `zero_flag`=0, IDLE, and a correct restart on the next `start`.
